// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready channel between the fetch unit and the
// instruction memory. Only one request is outstanding at a time.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, runs the single-outstanding imem handshake and
// drives the IF/ID register, handling hazard stalls and redirect squashes.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             PCSource,
  input  logic [31:0]            PC_branch,
  input  logic [31:0]            PC_jump,
  input  logic                   Stall,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            Instr_IF,
  output logic [31:0]            PC_IF,
  output logic [31:0]            PC_plus4_IF,
  output logic                   Valid_IF
);

  typedef enum logic [1:0] {FETCH, DROP, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] fetch_addr_reg, fetch_addr_next;
  logic [31:0] hold_instr_reg, hold_instr_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [31:0] instr_if_reg, instr_if_next;
  logic [31:0] pc_if_reg, pc_if_next;
  logic [31:0] pc_plus4_if_reg, pc_plus4_if_next;
  logic        valid_if_reg, valid_if_next;

  logic        redirect;
  logic        xfer;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] fetch_addr_plus4;

  assign redirect         = (PCSource != 2'd0);
  assign xfer             = imem.imem_req & imem.imem_ready;
  assign fetch_addr_plus4 = fetch_addr_reg + 32'd4;

  always_comb begin
    target_raw = PC_branch;
    case (PCSource)
      2'd1:    target_raw = PC_branch;
      2'd2:    target_raw = PC_jump;
      2'd3:    target_raw = EXC_VECTOR;
      default: target_raw = PC_branch;
    endcase
  end
  assign target = target_raw & ~32'h3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: begin
        if (redirect)           state_next = xfer ? FETCH : DROP;
        else if (xfer && Stall) state_next = HOLD;
      end
      DROP:    if (xfer) state_next = FETCH;
      HOLD:    if (redirect || !Stall) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // The address stays on the bus until accepted; HOLD keeps the bus idle.
  always_comb begin
    imem.imem_req  = (state_reg != HOLD);
    imem.imem_addr = fetch_addr_reg;
  end

  always_comb begin
    pc_next          = pc_reg;
    fetch_addr_next  = fetch_addr_reg;
    hold_instr_next  = hold_instr_reg;
    hold_pc_next     = hold_pc_reg;
    instr_if_next    = instr_if_reg;
    pc_if_next       = pc_if_reg;
    pc_plus4_if_next = pc_plus4_if_reg;
    valid_if_next    = valid_if_reg;
    case (state_reg)
      FETCH: begin
        if (redirect) begin
          pc_next       = target;
          valid_if_next = 1'b0;
          if (xfer) fetch_addr_next = target;
        end else if (xfer && !Stall) begin
          instr_if_next    = imem.imem_rdata;
          pc_if_next       = fetch_addr_reg;
          pc_plus4_if_next = fetch_addr_plus4;
          valid_if_next    = 1'b1;
          pc_next          = fetch_addr_plus4;
          fetch_addr_next  = fetch_addr_plus4;
        end else if (xfer) begin
          hold_instr_next = imem.imem_rdata;
          hold_pc_next    = fetch_addr_reg;
          pc_next         = fetch_addr_plus4;
          fetch_addr_next = fetch_addr_plus4;
        end else if (!Stall) begin
          valid_if_next = 1'b0;
        end
      end
      DROP: begin
        // Wrong-path response is discarded; resume at the newest target.
        if (redirect) pc_next = target;
        if (redirect || !Stall) valid_if_next = 1'b0;
        if (xfer) fetch_addr_next = redirect ? target : pc_reg;
      end
      HOLD: begin
        if (redirect) begin
          pc_next         = target;
          fetch_addr_next = target;
          valid_if_next   = 1'b0;
        end else if (!Stall) begin
          instr_if_next    = hold_instr_reg;
          pc_if_next       = hold_pc_reg;
          pc_plus4_if_next = hold_pc_reg + 32'd4;
          valid_if_next    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg          <= RESET_VECTOR;
      fetch_addr_reg  <= RESET_VECTOR;
      hold_instr_reg  <= 32'd0;
      hold_pc_reg     <= 32'd0;
      instr_if_reg    <= 32'd0;
      pc_if_reg       <= 32'd0;
      pc_plus4_if_reg <= 32'd0;
      valid_if_reg    <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      fetch_addr_reg  <= fetch_addr_next;
      hold_instr_reg  <= hold_instr_next;
      hold_pc_reg     <= hold_pc_next;
      instr_if_reg    <= instr_if_next;
      pc_if_reg       <= pc_if_next;
      pc_plus4_if_reg <= pc_plus4_if_next;
      valid_if_reg    <= valid_if_next;
    end
  end

  assign Instr_IF    = instr_if_reg;
  assign PC_IF       = pc_if_reg;
  assign PC_plus4_IF = pc_plus4_if_reg;
  assign Valid_IF    = valid_if_reg;

endmodule
